// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM port controller: FSM states,
// requester ownership and the access-size decode.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

    typedef enum logic {
        OwnerIF  = 1'b0,
        OwnerMEM = 1'b1
    } owner_e;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b11;

    // Code 10 is not a legal size but is served as a full word.
    function automatic logic [2:0] sizeToBytes(input logic [1:0] size);
        case (size)
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the MEM
// stage, serialising little-endian 1/2/4-byte accesses one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_r_req_i,
    input  logic              mem_w_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_w_data_i,
    input  logic [1:0]        mem_state_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_r_data_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          nBytes_q, nBytes_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         wData_q, wData_d;
    logic [31:0]         rdBuf_q, rdBuf_d;

    logic                ifDone_q, ifDone_d;
    logic [31:0]         ifData_q, ifData_d;
    logic                memDone_q, memDone_d;
    logic [31:0]         memRData_q, memRData_d;
    logic [7:0]          ramDout_q, ramDout_d;
    logic [ADDR_W-1:0]   ramAddr_q, ramAddr_d;
    logic                ramWr_q, ramWr_d;

    logic [2:0]          nextCnt;
    logic [1:0]          capLane;
    logic [1:0]          wrLane;
    logic [ADDR_W-1:0]   addrNext;
    logic [31:0]         capBuf;

    // In READ, cnt_q addresses byte cnt_q while the byte addressed one cycle
    // earlier (lane cnt_q-1) arrives on ram_din_i.
    assign nextCnt  = cnt_q + 3'd1;
    assign capLane  = 2'(cnt_q - 3'd1);
    assign wrLane   = nextCnt[1:0];
    assign addrNext = addr_q + ADDR_W'(nextCnt);

    always_comb begin
        capBuf = rdBuf_q;
        capBuf[{capLane, 3'b000} +: 8] = ram_din_i;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        nBytes_d   = nBytes_q;
        cnt_d      = cnt_q;
        wData_d    = wData_q;
        rdBuf_d    = rdBuf_q;
        ifDone_d   = 1'b0;
        ifData_d   = ifData_q;
        memDone_d  = 1'b0;
        memRData_d = memRData_q;
        ramDout_d  = 8'h00;
        ramAddr_d  = '0;
        ramWr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_w_req_i) begin
                    state_d   = WRITE;
                    owner_d   = OwnerMEM;
                    addr_d    = mem_addr_i;
                    nBytes_d  = sizeToBytes(mem_state_i);
                    cnt_d     = 3'd0;
                    wData_d   = mem_w_data_i;
                    ramWr_d   = 1'b1;
                    ramAddr_d = mem_addr_i;
                    ramDout_d = mem_w_data_i[7:0];
                end else if (mem_r_req_i) begin
                    state_d   = READ;
                    owner_d   = OwnerMEM;
                    addr_d    = mem_addr_i;
                    nBytes_d  = sizeToBytes(mem_state_i);
                    cnt_d     = 3'd0;
                    rdBuf_d   = '0;
                    ramAddr_d = mem_addr_i;
                end else if (if_req_i && !if_flush_i) begin
                    state_d   = READ;
                    owner_d   = OwnerIF;
                    addr_d    = if_addr_i;
                    nBytes_d  = 3'd4;
                    cnt_d     = 3'd0;
                    rdBuf_d   = '0;
                    ramAddr_d = if_addr_i;
                end
            end

            READ: begin
                if (owner_q == OwnerIF && if_flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 3'd0) begin
                        rdBuf_d = capBuf;
                    end
                    if (cnt_q == nBytes_q) begin
                        state_d = DONE;
                        if (owner_q == OwnerMEM) begin
                            memDone_d  = 1'b1;
                            memRData_d = capBuf;
                        end else begin
                            ifDone_d = 1'b1;
                            ifData_d = capBuf;
                        end
                    end else begin
                        cnt_d = nextCnt;
                        if (nextCnt < nBytes_q) begin
                            ramAddr_d = addrNext;
                        end
                    end
                end
            end

            WRITE: begin
                if (cnt_q == nBytes_q - 3'd1) begin
                    state_d   = DONE;
                    memDone_d = 1'b1;
                end else begin
                    cnt_d     = nextCnt;
                    ramWr_d   = 1'b1;
                    ramAddr_d = addrNext;
                    ramDout_d = wData_q[{wrLane, 3'b000} +: 8];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OwnerIF;
            addr_q     <= '0;
            nBytes_q   <= 3'd0;
            cnt_q      <= 3'd0;
            wData_q    <= '0;
            rdBuf_q    <= '0;
            ifDone_q   <= 1'b0;
            ifData_q   <= '0;
            memDone_q  <= 1'b0;
            memRData_q <= '0;
            ramDout_q  <= 8'h00;
            ramAddr_q  <= '0;
            ramWr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            nBytes_q   <= nBytes_d;
            cnt_q      <= cnt_d;
            wData_q    <= wData_d;
            rdBuf_q    <= rdBuf_d;
            ifDone_q   <= ifDone_d;
            ifData_q   <= ifData_d;
            memDone_q  <= memDone_d;
            memRData_q <= memRData_d;
            ramDout_q  <= ramDout_d;
            ramAddr_q  <= ramAddr_d;
            ramWr_q    <= ramWr_d;
        end
    end

    assign if_done_o    = ifDone_q;
    assign if_data_o    = ifData_q;
    assign mem_done_o   = memDone_q;
    assign mem_r_data_o = memRData_q;
    assign ram_dout_o   = ramDout_q;
    assign ram_addr_o   = ramAddr_q;
    assign ram_wr_o     = ramWr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl; a small byte RAM answers reads one cycle
// after the address, and every check compares against hand-computed values.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_flush_i = 1'b0;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_r_req_i = 1'b0;
    logic        mem_w_req_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_w_data_i = '0;
    logic [1:0]  mem_state_i = 2'b00;
    logic        mem_done_o;
    logic [31:0] mem_r_data_o;
    logic [7:0]  ram_din_i = 8'h00;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;

    logic [7:0]  ramMem [0:511];
    int          vecCount = 0;
    int          missCount = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_flush_i   (if_flush_i),
        .if_done_o    (if_done_o),
        .if_data_o    (if_data_o),
        .mem_r_req_i  (mem_r_req_i),
        .mem_w_req_i  (mem_w_req_i),
        .mem_addr_i   (mem_addr_i),
        .mem_w_data_i (mem_w_data_i),
        .mem_state_i  (mem_state_i),
        .mem_done_o   (mem_done_o),
        .mem_r_data_o (mem_r_data_o),
        .ram_din_i    (ram_din_i),
        .ram_dout_o   (ram_dout_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wr_o     (ram_wr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_din_i <= ramMem[ram_addr_o[8:0]];

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [106:0] allOut;
        if_req_i  = 1'b1;
        if_addr_i = 32'h80;
        for (int c = 0; c < 2; c++) begin
            tick();
            allOut = {if_done_o, if_data_o, mem_done_o, mem_r_data_o, ram_dout_o, ram_addr_o, ram_wr_o};
            vecCount++;
            if (allOut !== '0) begin
                missCount++;
                $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
            end
        end
        rst = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 4) begin
                vecCount++;
                if (ram_addr_o !== 32'(32'h80 + c - 1) || ram_wr_o !== 1'b0) begin
                    missCount++;
                    $display("[TB] FAIL reset_first_grant_addr c%0d: got %h wr %b expected %h wr 0",
                             c, ram_addr_o, ram_wr_o, 32'(32'h80 + c - 1));
                end
            end
            vecCount++;
            if (if_done_o !== (c == 6)) begin
                missCount++;
                $display("[TB] FAIL reset_if_done c%0d: got %b expected %b", c, if_done_o, (c == 6));
            end
            if (c == 6) begin
                vecCount++;
                if (if_data_o !== 32'h04030201) begin
                    missCount++;
                    $display("[TB] FAIL reset_if_data: got %h expected 04030201", if_data_o);
                end
                if_req_i = 1'b0;
            end
        end
    endtask

    task automatic test_lw();
        mem_r_req_i = 1'b1;
        mem_addr_i  = 32'h100;
        mem_state_i = 2'b11;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 4) begin
                vecCount++;
                if (ram_addr_o !== 32'(32'h100 + c - 1) || ram_wr_o !== 1'b0) begin
                    missCount++;
                    $display("[TB] FAIL lw_addr c%0d: got %h wr %b expected %h wr 0",
                             c, ram_addr_o, ram_wr_o, 32'(32'h100 + c - 1));
                end
            end
            vecCount++;
            if (mem_done_o !== (c == 6) || if_done_o !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL lw_done c%0d: got mem %b if %b expected mem %b if 0",
                         c, mem_done_o, if_done_o, (c == 6));
            end
            if (c == 6) begin
                vecCount++;
                if (mem_r_data_o !== 32'h44332211 || if_data_o !== 32'h04030201) begin
                    missCount++;
                    $display("[TB] FAIL lw_data: got mem %h if %h expected mem 44332211 if 04030201",
                             mem_r_data_o, if_data_o);
                end
                mem_r_req_i = 1'b0;
            end
        end
    endtask

    task automatic test_sb();
        // Read and write asserted together: the write must be the one served.
        mem_w_req_i  = 1'b1;
        mem_r_req_i  = 1'b1;
        mem_addr_i   = 32'h20;
        mem_w_data_i = 32'hDEADBEEF;
        mem_state_i  = 2'b00;
        tick();
        vecCount++;
        if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h20 || ram_dout_o !== 8'hEF || mem_done_o !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL sb_write: got wr %b addr %h dout %h done %b expected wr 1 addr 20 dout ef done 0",
                     ram_wr_o, ram_addr_o, ram_dout_o, mem_done_o);
        end
        tick();
        vecCount++;
        if (mem_done_o !== 1'b1 || ram_wr_o !== 1'b0 || mem_r_data_o !== 32'h44332211) begin
            missCount++;
            $display("[TB] FAIL sb_done: got done %b wr %b rdata %h expected done 1 wr 0 rdata 44332211",
                     mem_done_o, ram_wr_o, mem_r_data_o);
        end
        mem_w_req_i = 1'b0;
        mem_r_req_i = 1'b0;
        tick();
        vecCount++;
        if (mem_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL sb_after: got done %b wr %b expected 0 0", mem_done_o, ram_wr_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        wd = 32'hA1B2C3D4;
        ramMem[9'h080] = 8'h5A;
        ramMem[9'h081] = 8'h6B;
        ramMem[9'h082] = 8'h7C;
        ramMem[9'h083] = 8'h8D;
        if_req_i     = 1'b1;
        if_addr_i    = 32'h80;
        mem_w_req_i  = 1'b1;
        mem_addr_i   = 32'h40;
        mem_w_data_i = wd;
        mem_state_i  = 2'b11;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c <= 4) begin
                vecCount++;
                if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'(32'h40 + c - 1) || ram_dout_o !== wd[8*(c-1) +: 8]) begin
                    missCount++;
                    $display("[TB] FAIL b2b_write c%0d: got wr %b addr %h dout %h expected wr 1 addr %h dout %h",
                             c, ram_wr_o, ram_addr_o, ram_dout_o, 32'(32'h40 + c - 1), wd[8*(c-1) +: 8]);
                end
            end
            if (c >= 5) begin
                vecCount++;
                if (ram_wr_o !== 1'b0) begin
                    missCount++;
                    $display("[TB] FAIL b2b_wr_low c%0d: got %b expected 0", c, ram_wr_o);
                end
            end
            if (c >= 7 && c <= 10) begin
                vecCount++;
                if (ram_addr_o !== 32'(32'h80 + c - 7)) begin
                    missCount++;
                    $display("[TB] FAIL b2b_if_addr c%0d: got %h expected %h", c, ram_addr_o, 32'(32'h80 + c - 7));
                end
            end
            vecCount++;
            if (mem_done_o !== (c == 5) || if_done_o !== (c == 12)) begin
                missCount++;
                $display("[TB] FAIL b2b_done c%0d: got mem %b if %b expected mem %b if %b",
                         c, mem_done_o, if_done_o, (c == 5), (c == 12));
            end
            if (c == 5) mem_w_req_i = 1'b0;
            if (c == 12) begin
                vecCount++;
                if (if_data_o !== 32'h8D7C6B5A) begin
                    missCount++;
                    $display("[TB] FAIL b2b_if_data: got %h expected 8d7c6b5a", if_data_o);
                end
                if_req_i = 1'b0;
            end
        end
    endtask

    task automatic test_flush();
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 3) begin
                vecCount++;
                if (ram_addr_o !== 32'(32'h100 + c - 1)) begin
                    missCount++;
                    $display("[TB] FAIL flush_addr c%0d: got %h expected %h", c, ram_addr_o, 32'(32'h100 + c - 1));
                end
            end else begin
                vecCount++;
                if (ram_addr_o !== 32'h0 || ram_wr_o !== 1'b0) begin
                    missCount++;
                    $display("[TB] FAIL flush_idle c%0d: got addr %h wr %b expected addr 0 wr 0", c, ram_addr_o, ram_wr_o);
                end
            end
            vecCount++;
            if (if_done_o !== 1'b0 || if_data_o !== 32'h8D7C6B5A) begin
                missCount++;
                $display("[TB] FAIL flush_no_done c%0d: got done %b data %h expected done 0 data 8d7c6b5a",
                         c, if_done_o, if_data_o);
            end
            if (c == 3) if_flush_i = 1'b1;
            if (c == 6) begin
                if_flush_i = 1'b0;
                if_req_i   = 1'b0;
            end
        end
    endtask

    task automatic test_lh_wrap();
        ramMem[9'h1FF] = 8'hAB;
        ramMem[9'h000] = 8'hCD;
        mem_r_req_i = 1'b1;
        mem_addr_i  = 32'hFFFF_FFFF;
        mem_state_i = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1 || c == 2) begin
                vecCount++;
                if (ram_addr_o !== ((c == 1) ? 32'hFFFF_FFFF : 32'h0)) begin
                    missCount++;
                    $display("[TB] FAIL lh_wrap_addr c%0d: got %h expected %h",
                             c, ram_addr_o, ((c == 1) ? 32'hFFFF_FFFF : 32'h0));
                end
            end
            vecCount++;
            if (mem_done_o !== (c == 4)) begin
                missCount++;
                $display("[TB] FAIL lh_done c%0d: got %b expected %b", c, mem_done_o, (c == 4));
            end
            if (c == 4) begin
                vecCount++;
                if (mem_r_data_o !== 32'h0000CDAB) begin
                    missCount++;
                    $display("[TB] FAIL lh_data: got %h expected 0000cdab", mem_r_data_o);
                end
                mem_r_req_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [106:0] allOut;
        mem_w_req_i  = 1'b1;
        mem_addr_i   = 32'h40;
        mem_w_data_i = 32'h01020304;
        mem_state_i  = 2'b11;
        tick();
        tick();
        rst         = 1'b0;
        mem_w_req_i = 1'b0;
        tick();
        allOut = {if_done_o, if_data_o, mem_done_o, mem_r_data_o, ram_dout_o, ram_addr_o, ram_wr_o};
        vecCount++;
        if (allOut !== '0) begin
            missCount++;
            $display("[TB] FAIL reset_abort: got %h expected 0", allOut);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vecCount++;
            if (ram_wr_o !== 1'b0 || mem_done_o !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL reset_abort_idle c%0d: got wr %b done %b expected 0 0", c, ram_wr_o, mem_done_o);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ramMem[i] = 8'h00;
        ramMem[9'h080] = 8'h01;
        ramMem[9'h081] = 8'h02;
        ramMem[9'h082] = 8'h03;
        ramMem[9'h083] = 8'h04;
        ramMem[9'h100] = 8'h11;
        ramMem[9'h101] = 8'h22;
        ramMem[9'h102] = 8'h33;
        ramMem[9'h103] = 8'h44;

        test_reset();
        test_lw();
        test_sb();
        test_back_to_back();
        test_flush();
        test_lh_wrap();
        test_reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
